hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Sequential HI/LO unit in the execute stage, sitting directly downstream of the combinational ALU.
- Captures the ALU's 64-bit multu product (lo word and hi word) into architectural HI/LO registers.
- Performs iterative signed/unsigned 32-bit division (one quotient bit per cycle) and services mthi/mtlo writes.
- Raises busy so the pipeline controller stalls mfhi/mflo and any new HI/LO op until the result is committed.

Parameters:
WIDTH, 32, operand/register width; the divider iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  op request, valid for one cycle; only accepted when busy=0
op  input  3  0=NOP, 1=MULTU_WR, 2=DIVU, 3=DIV, 4=MTHI, 5=MTLO, 6/7=NOP
a  input  WIDTH  dividend (DIV/DIVU) or source value (MTHI/MTLO)
b  input  WIDTH  divisor
alu_lo  input  WIDTH  ALU r output (product low word)
alu_hi  input  WIDTH  ALU r2 output (product high word)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  division in progress
done  output  1  one-cycle pulse: HI/LO were updated on the preceding edge

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- On reset: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0, internal quotient/remainder/sign flags=0.
- Reset asserted mid-division aborts the division; HI/LO return to 0.
- States: IDLE, DIVIDE, FIXUP.
- IDLE, start=1, op=MULTU_WR: at that edge hi<=alu_hi, lo<=alu_lo; done=1 for the following cycle; busy stays 0.
- IDLE, start=1, op=MTHI: hi<=a, lo unchanged, done pulse.
- IDLE, start=1, op=MTLO: lo<=a, hi unchanged, done pulse.
- IDLE, start=1, op=NOP or 6/7: no change, no done.
- IDLE, start=1, op=DIVU/DIV, b!=0: latch the operands.
  - DIV: latch |a| and |b|, and record sign_q = a[31]^b[31] and sign_r = a[31].
  - Go to DIVIDE; busy=1 from the next cycle.
  - Counter loads WIDTH.
- DIVIDE: restoring division, one step per edge.
  - Shift the remainder left, bringing in the next dividend MSB.
  - If remainder>=divisor: subtract and shift in quotient bit 1, else shift in 0.
  - Counter decrements; after WIDTH steps go to FIXUP.
- FIXUP, one edge:
  - Apply signs for DIV: quotient negated if sign_q, remainder negated if sign_r.
  - lo<=quotient, hi<=remainder; go to IDLE; busy falls; done=1 for one cycle.
- Latency: with start at edge E0, busy is high after E0 through E33, HI/LO are written at edge E(WIDTH+1)=E33, and done is high during the cycle after E33.
- Divide by zero (b==0, DIV or DIVU): no iteration. At the start edge lo<=all-ones, hi<=a (raw); done pulse; busy stays 0.
- DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural two's-complement wrap; no trap.
- Signed rounding: quotient truncates toward zero; remainder carries the sign of the dividend.
- start while busy=1 is ignored entirely, with no queuing. The controller must hold the request.
- a, b, alu_lo, alu_hi are sampled only at the accepting edge. Changes during DIVIDE have no effect.
- hi/lo are stable registered outputs, changing only at the commit edges listed above.

Test Plan:
- Reset then MULTU_WR with alu_hi=0x00000001, alu_lo=0xFFFFFFFE -> next cycle hi=0x00000001, lo=0xFFFFFFFE, done=1 for one cycle, busy=0 throughout.
- DIVU a=100, b=7 -> busy high for 33 cycles; then lo=14, hi=2, one done pulse.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> next cycle lo=0xFFFFFFFF, hi=5, busy never set.
- During a DIVU (a=100, b=7), pulse start with MTHI a=0xDEADBEEF at cycle 10 -> the MTHI is ignored; final hi=2, lo=14.
- Drop rst_n low at cycle 15 of a DIV -> hi=0, lo=0, busy=0 immediately. After release, MTLO a=0x12345678 -> lo=0x12345678.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO unit for the execute stage. It captures the multu product and handles mthi/mtlo writes.
// It also runs an iterative restoring divider (signed or unsigned) that produces one quotient bit per cycle.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic [WIDTH-1:0] alu_hi,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;   // holds the dividend, then shifts into the quotient
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             is_div;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    is_div = (op == OP_DIV);
    // The magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
    abs_a  = (is_div && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b  = (is_div && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (op)
            OP_MULTU: begin
              hi   <= alu_hi;
              lo   <= alu_lo;
              done <= 1'b1;
            end
            OP_MTHI: begin
              hi   <= a;
              done <= 1'b1;
            end
            OP_MTLO: begin
              lo   <= a;
              done <= 1'b1;
            end
            OP_DIVU, OP_DIV: begin
              if (b == '0) begin
                lo   <= '1;
                hi   <= a;
                done <= 1'b1;
              end else begin
                quo    <= abs_a;
                dvs    <= abs_b;
                rem    <= '0;
                sign_q <= is_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                sign_r <= is_div & a[WIDTH-1];
                cnt    <= CW'(WIDTH);
                busy   <= 1'b1;
                state  <= DIVIDE;
              end
            end
            default: ;
          endcase
        end
        DIVIDE: begin
          rem <= rem_nx;
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          lo    <= sign_q ? (~quo + 1'b1) : quo;
          hi    <= sign_r ? (~rem + 1'b1) : rem;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed scenarios, then random ops checked against an arithmetic model.
module tb_hilo_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, alu_lo = '0, alu_hi = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .alu_lo(alu_lo), .alu_hi(alu_hi), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: architectural division results computed with plain arithmetic.
  function automatic void ref_div(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sx, sy;
    if (y == 0) begin
      q = '1; r = x;
    end else if (o == 3'd2) begin
      q = x / y; r = x % y;
    end else begin
      sx = longint'($signed(x)); sy = longint'($signed(y));
      q = W'(sx / sy); r = W'(sx % sy);
    end
  endfunction

  // Presents one request across a single posedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] plo, input logic [W-1:0] phi);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; alu_lo = plo; alu_hi = phi;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    alu_lo = $urandom; alu_hi = $urandom;
  endtask

  // Waits for done and counts the busy cycles seen on the way; reports a timeout if done never comes.
  task automatic wait_done(output int busy_cyc, output bit timeout);
    busy_cyc = 0; timeout = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) return;
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    issue(3'd1, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001);
    n_tests++;
    if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL multu: hi=%h lo=%h done=%b busy=%b, required 00000001 fffffffe 1 0", hi, lo, done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h1) begin
      n_fail++;
      $display("FAIL multu_pulse: done=%b busy=%b hi=%h, required 0 0 00000001", done, busy, hi);
    end
  endtask

  task automatic test_div(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int bc; bit to;
    issue(o, x, y, '0, '0);
    wait_done(bc, to);
    n_tests++;
    if (to || lo !== exp_lo || hi !== exp_hi || bc != 33) begin
      n_fail++;
      $display("FAIL div op%0d %h/%h: lo=%h hi=%h busy_cycles=%0d timeout=%b, required lo=%h hi=%h 33 cycles",
               o, x, y, lo, hi, bc, to, exp_lo, exp_hi);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_pulse: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_divzero();
    issue(3'd2, 32'd5, 32'd0, '0, '0);
    n_tests++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd5 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero: lo=%h hi=%h done=%b busy=%b, required ffffffff 00000005 1 0", lo, hi, done, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int bc; bit to;
    issue(3'd2, 32'd100, 32'd7, '0, '0);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || hi === 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL busy_ignore_mid: busy=%b done=%b hi=%h, required busy 1, no done, hi untouched", busy, done, hi);
    end
    wait_done(bc, to);
    n_tests++;
    if (to || hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++;
      $display("FAIL busy_ignore: hi=%h lo=%h timeout=%b, required 00000002 0000000e", hi, lo, to);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, '0, '0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, required 0 0 0 0", hi, lo, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd5, 32'h1234_5678, '0, '0, '0);
    n_tests++;
    if (lo !== 32'h1234_5678 || hi !== '0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL mtlo_after_reset: lo=%h hi=%h done=%b, required 12345678 00000000 1", lo, hi, done);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] m_hi, m_lo, x, y, pl, ph, q, r;
    logic [2:0]   o;
    int bc; bit to, dv;
    m_hi = hi; m_lo = lo;
    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      x  = $urandom; pl = $urandom; ph = $urandom;
      y  = ($urandom_range(0, 5) == 0) ? '0 : (($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : $urandom);
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      dv = (o == 3'd2 || o == 3'd3);
      case (o)
        3'd1: begin m_hi = ph; m_lo = pl; end
        3'd4: m_hi = x;
        3'd5: m_lo = x;
        3'd2, 3'd3: begin ref_div(o, x, y, q, r); m_lo = q; m_hi = r; end
        default: ;
      endcase
      issue(o, x, y, pl, ph);
      if (dv && y != 0) wait_done(bc, to);
      else begin bc = 0; to = 1'b0; end
      n_tests++;
      if (to || hi !== m_hi || lo !== m_lo || done !== (o inside {[3'd1:3'd5]})) begin
        n_fail++;
        $display("FAIL random[%0d] op%0d a=%h b=%h: hi=%h lo=%h done=%b timeout=%b, required hi=%h lo=%h",
                 i, o, x, y, hi, lo, done, to, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_div(3'd2, 32'd100, 32'd7, 32'd14, 32'd2);
    test_div(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    test_div(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
    test_div(3'd3, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    test_div(3'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    test_divzero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
